// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the IF/MEM single-port RAM arbiter.
package mem_port_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_MEM  = 2'b10
   } owner_e;

   typedef struct packed {
      owner_e     owner;
      logic [1:0] offset;
   } tracker_t;

   // Size code 11 behaves like a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return offset[0];
         default:   return offset != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_lane_gen.sv
// Store lane steering: byte enables, replicated write data and alignment check.
module byte_lane_gen
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic        misaligned
);

   always_comb begin
      be         = 4'b1111;
      lane_wdata = wdata;
      case (size)
         SIZE_BYTE: begin
            be         = 4'b0001 << offset;
            lane_wdata = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            be         = 4'b0011 << offset;
            lane_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign misaligned = is_misaligned(size, offset);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified RAM between fetch and data ports, with bounded fetch starvation
// and one-cycle-late read data routed back to the issuing port.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DATA_STREAK = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic        mem_err,
   output logic        mem_rvalid,
   output logic [31:0] mem_rdata,
   output logic        ram_en,
   output logic [3:0]  ram_be,
   output logic [29:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        stall_if
);

   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

   logic        grant_mem;
   logic        grant_if;
   logic        misaligned;
   logic        mem_access;
   logic [31:0] sel_addr;
   logic [3:0]  lane_be;
   logic [3:0]  streak;
   logic [3:0]  streak_next;
   tracker_t    tracker;
   tracker_t    tracker_next;

   assign grant_mem = mem_req && !(if_req && streak >= STREAK_LIMIT);
   assign grant_if  = if_req && !grant_mem;

   // Single address path; the lane generator only sees the fetch offset when its outputs are unused.
   assign sel_addr = grant_if ? if_addr : mem_addr;

   byte_lane_gen u_lanes (
      .size       (mem_size),
      .offset     (sel_addr[1:0]),
      .wdata      (mem_wdata),
      .be         (lane_be),
      .lane_wdata (ram_wdata),
      .misaligned (misaligned)
   );

   assign mem_access = grant_mem && !misaligned;

   assign if_ready  = grant_if;
   assign mem_ready = grant_mem;
   assign mem_err   = grant_mem && misaligned;
   assign ram_en    = grant_if || mem_access;
   assign ram_be    = (mem_access && mem_we) ? lane_be : 4'b0000;
   assign ram_addr  = sel_addr[31:2];
   assign stall_if  = if_req && !grant_if;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      tracker_next = '{owner: OWN_NONE, offset: 2'b00};
      streak_next  = streak;
      if (grant_if) begin
         tracker_next.owner = OWN_IF;
      end else if (mem_access && !mem_we) begin
         tracker_next.owner  = OWN_MEM;
         tracker_next.offset = sel_addr[1:0];
      end
      if (!if_req || grant_if) begin
         streak_next = '0;
      end else if (grant_mem && streak < STREAK_LIMIT) begin
         streak_next = streak + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         streak  <= '0;
         tracker <= '{owner: OWN_NONE, offset: 2'b00};
      end else begin
         streak  <= streak_next;
         tracker <= tracker_next;
      end
   end

   assign if_rvalid  = tracker.owner == OWN_IF;
   assign mem_rvalid = tracker.owner == OWN_MEM;
   assign if_rdata   = ram_rdata;
   assign mem_rdata  = ram_rdata >> {tracker.offset, 3'b000};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: byte-level memory model plus directed literal cases.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int MAX = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_ready, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        mem_req, mem_we, mem_ready, mem_err, mem_rvalid;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        ram_en;
   logic [3:0]  ram_be;
   logic [29:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        stall_if;

   logic        pre_we;
   logic [3:0]  pre_idx;
   logic [31:0] pre_word;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic [7:0]  m_mem [64];
   int          m_streak;
   int          m_resp;       // 0 none, 1 fetch, 2 load
   logic [31:0] m_resp_data;
   logic        m_gi, m_gm;

   mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_err(mem_err), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ram_en(ram_en), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall_if(stall_if)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, 16 words.
   logic [31:0] ram [16];
   always @(posedge clk) begin
      if (pre_we) begin
         ram[pre_idx] <= pre_word;
      end else if (ram_en) begin
         if (ram_be == 4'b0000) ram_rdata <= ram[ram_addr[3:0]];
         else for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_streak = 0;
      m_resp   = 0;
   endtask

   // Compare every output against the model, then advance the model by one cycle.
   task automatic model_check();
      logic        mis, gm, gi, store, load;
      logic [1:0]  off;
      logic [3:0]  be;
      logic [31:0] wd, rd;
      int          n, base;
      check("if_rvalid", 32'(if_rvalid), 32'(m_resp == 1));
      check("mem_rvalid", 32'(mem_rvalid), 32'(m_resp == 2));
      if (m_resp == 1) check("if_rdata", if_rdata, m_resp_data);
      if (m_resp == 2) check("mem_rdata", mem_rdata, m_resp_data);

      off = mem_addr[1:0];
      n   = (mem_size == SIZE_BYTE) ? 1 : (mem_size == SIZE_HALF) ? 2 : 4;
      mis = (n == 2 && off[0]) || (n == 4 && off != 2'b00);
      gm  = mem_req && !(if_req && m_streak >= MAX);
      gi  = if_req && !gm;
      store = gm && !mis && mem_we;
      load  = gm && !mis && !mem_we;

      check("mem_ready", 32'(mem_ready), 32'(gm));
      check("mem_err", 32'(mem_err), 32'(gm && mis));
      check("if_ready", 32'(if_ready), 32'(gi));
      check("stall_if", 32'(stall_if), 32'(if_req && !gi));
      check("ram_en", 32'(ram_en), 32'(gi || store || load));
      be = 4'b0000;
      if (store) for (int i = 0; i < n; i++) be[off + 2'(i)] = 1'b1;
      check("ram_be", 32'(ram_be), 32'(be));
      if (gi) check("ram_addr_if", 32'(ram_addr), 32'(if_addr >> 2));
      if (store || load) check("ram_addr_mem", 32'(ram_addr), 32'(mem_addr >> 2));

      base = int'(mem_addr[5:2]) * 4;
      if (store) begin
         for (int k = 0; k < 4; k++) wd[8*k +: 8] = mem_wdata[8*(k % n) +: 8];
         check("ram_wdata", ram_wdata, wd);
         for (int i = 0; i < n; i++) m_mem[base + int'(off) + i] = mem_wdata[8*i +: 8];
      end

      m_resp = 0;
      if (gi) begin
         for (int k = 0; k < 4; k++) rd[8*k +: 8] = m_mem[int'(if_addr[5:2]) * 4 + k];
         m_resp = 1;
         m_resp_data = rd;
      end else if (load) begin
         for (int k = 0; k < 4; k++)
            rd[8*k +: 8] = (k + int'(off) < 4) ? m_mem[base + k + int'(off)] : 8'h00;
         m_resp = 2;
         m_resp_data = rd;
      end
      if (!if_req || gi) m_streak = 0;
      else if (gm && m_streak < MAX) m_streak++;
      if (!rst) model_reset();
      m_gi = gi;
      m_gm = gm;
   endtask

   task automatic settle();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int idx, input logic [31:0] word);
      pre_we   = 1'b1;
      pre_idx  = 4'(idx);
      pre_word = word;
      for (int k = 0; k < 4; k++) m_mem[idx*4 + k] = word[8*k +: 8];
   endtask

   initial begin
      rst = 1'b0;
      if_req = 1'b0; if_addr = 32'h1000;
      mem_req = 1'b0; mem_we = 1'b0; mem_size = SIZE_WORD;
      mem_addr = 32'h1000; mem_wdata = '0;
      pre_we = 1'b0; pre_idx = '0; pre_word = '0;
      m_gi = 1'b0; m_gm = 1'b0; m_resp_data = '0;
      model_reset();

      for (int i = 0; i < 16; i++) begin
         preload(i, $urandom);
         advance();
      end
      pre_we = 1'b0;

      // Reset with both requests pending.
      if_req = 1'b1; if_addr = 32'h1000;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h1004;
      for (int k = 0; k < 2; k++) begin
         settle();
         check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
         check("rst_mem_rvalid", 32'(mem_rvalid), 32'd0);
         check("rst_streak", 32'(dut.streak), 32'd0);
         advance();
      end
      rst = 1'b1;

      // Grant pattern MEM, MEM, IF with both ports saturated.
      for (int k = 0; k < 9; k++) begin
         if (k > 0) begin
            advance();
            if (m_gm) mem_addr = 32'h1000 | 32'((k * 4) & 32'h3C);
            if (m_gi) if_addr = 32'h1000 | 32'((k * 8) & 32'h3C);
         end
         settle();
         check("grant_pattern", {30'd0, mem_ready, if_ready}, (k % 3 == 2) ? 32'd1 : 32'd2);
         if (k == 0) check("first_stall_if", 32'(stall_if), 32'd1);
      end
      advance(); if_req = 1'b0; mem_req = 1'b0;
      settle();

      // Byte store to the top lane.
      advance();
      mem_req = 1'b1; mem_we = 1'b1; mem_size = SIZE_BYTE;
      mem_addr = 32'h1003; mem_wdata = 32'h0000_00AB;
      settle();
      check("sb_be", 32'(ram_be), 32'b1000);
      check("sb_wdata", ram_wdata, 32'hABAB_ABAB);
      check("sb_addr", 32'(ram_addr), 32'h400);
      advance(); mem_req = 1'b0;
      settle();
      check("sb_no_rvalid", 32'(mem_rvalid), 32'd0);

      // Half load from the upper half of a known word.
      advance(); preload(0, 32'hBEEF_1234);
      settle();
      advance(); pre_we = 1'b0;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = SIZE_HALF; mem_addr = 32'h2002;
      settle();
      advance(); mem_req = 1'b0;
      settle();
      check("lh_rvalid", 32'(mem_rvalid), 32'd1);
      check("lh_rdata", mem_rdata, 32'h0000_BEEF);
      check("lh_if_rvalid", 32'(if_rvalid), 32'd0);

      // Misaligned word load beside a pending fetch.
      advance();
      if_req = 1'b1; if_addr = 32'h1010;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h2001;
      settle();
      check("mis_ready", 32'(mem_ready), 32'd1);
      check("mis_err", 32'(mem_err), 32'd1);
      check("mis_ram_en", 32'(ram_en), 32'd0);
      check("mis_if_ready", 32'(if_ready), 32'd0);
      advance(); mem_req = 1'b0;
      settle();
      check("mis_next_if_ready", 32'(if_ready), 32'd1);
      check("mis_no_rvalid", 32'(mem_rvalid), 32'd0);
      advance(); if_req = 1'b0;
      settle();

      // Reset while a load response is pending.
      advance();
      mem_req = 1'b1; mem_we = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h1008;
      settle();
      #2 rst = 1'b0;
      model_reset();
      advance(); mem_req = 1'b0;
      settle();
      check("rstp_rvalid", 32'(mem_rvalid), 32'd0);
      advance(); rst = 1'b1;
      settle();
      check("rstp_rvalid_after", 32'(mem_rvalid), 32'd0);
      check("rstp_owner", 32'(dut.tracker.owner), 32'(OWN_NONE));

      // Randomized traffic obeying the hold-until-ready protocol.
      for (int c = 0; c < 3000; c++) begin
         advance();
         if (!if_req || m_gi) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = 32'h1000 | 32'($urandom_range(0, 15) * 4);
         end
         if (!mem_req || m_gm) begin
            mem_req   = ($urandom_range(0, 2) != 0);
            mem_we    = 1'($urandom_range(0, 1));
            mem_size  = 2'($urandom_range(0, 3));
            mem_addr  = 32'h1000 | 32'($urandom_range(0, 63));
            mem_wdata = $urandom;
         end
         settle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
